// File: rtl/heichips25_pmux_pkg.sv
// Shared types and constants for the HeiChips project multiplexer.
package heichips25_pmux_pkg;

    localparam int NUM_PROJ_MAX = 4;
    localparam int CNT_W        = 4;
    localparam int PAD_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESET  = 2'd2,
        ST_ACTIVE = 2'd3
    } pmux_state_t;

endpackage

// File: rtl/heichips25_pmux_timer.sv
// Down-counter for DRAIN/RESET phases; loaded with (length-1), done at zero.
module heichips25_pmux_timer
    import heichips25_pmux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so an idle timer never wraps back to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/heichips25_project_mux.sv
// Selects which attached project owns the pads; drains and resets on every switch.
module heichips25_project_mux
    import heichips25_pmux_pkg::*;
#(
    parameter int NUM_PROJ     = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int RST_CYCLES   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sel_valid,
    input  logic [1:0]                sel_id,
    output logic                      sel_ready,
    input  logic [PAD_W*NUM_PROJ-1:0] uo_out_p,
    input  logic [PAD_W*NUM_PROJ-1:0] uio_out_p,
    input  logic [PAD_W*NUM_PROJ-1:0] uio_oe_p,
    output logic [NUM_PROJ-1:0]       proj_ena,
    output logic [NUM_PROJ-1:0]       proj_rst_n,
    output logic [PAD_W-1:0]          uo_out,
    output logic [PAD_W-1:0]          uio_out,
    output logic [PAD_W-1:0]          uio_oe,
    output logic [1:0]                active_id,
    output logic                      busy
);

    pmux_state_t      state, state_nxt;
    logic             run;
    logic [1:0]       target;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             enter_reset;

    heichips25_pmux_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    assign accept      = sel_valid && sel_ready;
    assign enter_reset = (state == ST_DRAIN) && (state_nxt == ST_RESET);

    // run holds sel_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            target    <= 2'd0;
            active_id <= 2'd0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (accept)
                target <= sel_id;
            if (enter_reset)
                active_id <= target;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (accept) begin
                    state_nxt = ST_DRAIN;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (tmr_done) begin
                    // An id beyond the attached projects deselects everything.
                    if (int'(target) < NUM_PROJ) begin
                        state_nxt = ST_RESET;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(RST_CYCLES - 1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RESET: begin
                if (tmr_done)
                    state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_ready  = run && ((state == ST_IDLE) || (state == ST_ACTIVE));
        busy       = (state == ST_DRAIN) || (state == ST_RESET);
        proj_ena   = '0;
        proj_rst_n = '0;
        uo_out     = '0;
        uio_out    = '0;
        uio_oe     = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (active_id == 2'(i)) begin
                proj_ena[i]   = (state == ST_RESET) || (state == ST_ACTIVE);
                proj_rst_n[i] = (state == ST_ACTIVE);
                if (state == ST_ACTIVE) begin
                    uo_out  = uo_out_p[i*PAD_W +: PAD_W];
                    uio_out = uio_out_p[i*PAD_W +: PAD_W];
                    uio_oe  = uio_oe_p[i*PAD_W +: PAD_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_heichips25_project_mux.sv
// Self-checking bench: directed switch scenarios plus random requests against a timeline model.
module tb_heichips25_project_mux;

    localparam int NP = 4;
    localparam int D  = 2;
    localparam int R  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_valid;
    logic [1:0]  sel_id;
    logic        sel_ready;
    logic [31:0] uo_p, uio_p, oe_p;
    logic [3:0]  ena, prst;
    logic [7:0]  uo, uio, oe;
    logic [1:0]  act;
    logic        busy;

    logic        v3;
    logic [1:0]  id3;
    logic        r3;
    logic [23:0] uo_p3, uio_p3, oe_p3;
    logic [2:0]  ena3, prst3;
    logic [7:0]  uo3, uio3, oe3;
    logic [1:0]  act3;
    logic        busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    heichips25_project_mux dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_id(sel_id),
        .sel_ready(sel_ready), .uo_out_p(uo_p), .uio_out_p(uio_p), .uio_oe_p(oe_p),
        .proj_ena(ena), .proj_rst_n(prst), .uo_out(uo), .uio_out(uio), .uio_oe(oe),
        .active_id(act), .busy(busy)
    );

    heichips25_project_mux #(.NUM_PROJ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel_valid(v3), .sel_id(id3),
        .sel_ready(r3), .uo_out_p(uo_p3), .uio_out_p(uio_p3), .uio_oe_p(oe_p3),
        .proj_ena(ena3), .proj_rst_n(prst3), .uo_out(uo3), .uio_out(uio3), .uio_oe(oe3),
        .active_id(act3), .busy(busy3)
    );

    // Reference: a switch is a timeline measured in edges since acceptance.
    bit         m_sw, m_rdy;
    int         m_age;
    logic [1:0] m_tgt, m_act;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int phase();  // 0 idle, 1 drain, 2 reset, 3 active
        if (!m_sw)                return 0;
        if (m_age < D)            return 1;
        if (int'(m_tgt) >= NP)    return 0;
        if (m_age < D + R)        return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_sw = 0; m_rdy = 0; m_age = 0; m_tgt = 0; m_act = 0;
    endtask

    task automatic model_step();
        int p;
        if (!rst_n) begin
            model_reset();
        end else begin
            p = phase();
            if (sel_valid && m_rdy && (p == 0 || p == 3)) begin
                m_sw = 1; m_age = 0; m_tgt = sel_id;
            end else if (m_sw && m_age < D + R) begin
                m_age++;
                if (m_age == D && int'(m_tgt) < NP) m_act = m_tgt;
            end
            m_rdy = 1;
        end
    endtask

    task automatic compare_model();
        int p;
        logic [3:0] oh;
        p  = phase();
        oh = 4'b0001 << m_act;
        chk("m_ready", sel_ready, m_rdy && (p == 0 || p == 3));
        chk("m_busy", busy, (p == 1 || p == 2));
        chk("m_active_id", act, m_act);
        chk("m_ena", ena, (p >= 2) ? oh : 4'b0);
        chk("m_rst_n", prst, (p == 3) ? oh : 4'b0);
        chk("m_uo", uo, (p == 3) ? (uo_p >> (8 * m_act)) & 32'hFF : 32'h0);
        chk("m_uio", uio, (p == 3) ? (uio_p >> (8 * m_act)) & 32'hFF : 32'h0);
        chk("m_oe", oe, (p == 3) ? (oe_p >> (8 * m_act)) & 32'hFF : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic request(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] id;
        logic [1:0] exp_act;
        logic [3:0] exp_rst_n;
        logic [3:0] exp_ena;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{id: 2'd3, exp_act: 2'd3, exp_rst_n: 4'b1000, exp_ena: 4'b1000};
        tbl[1] = '{id: 2'd1, exp_act: 2'd1, exp_rst_n: 4'b0010, exp_ena: 4'b0010};
        tbl[2] = '{id: 2'd1, exp_act: 2'd1, exp_rst_n: 4'b0010, exp_ena: 4'b0010};
        tbl[3] = '{id: 2'd0, exp_act: 2'd0, exp_rst_n: 4'b0001, exp_ena: 4'b0001};

        rst_n = 1'b0; sel_valid = 1'b0; sel_id = 2'd0;
        uo_p = $urandom; uio_p = $urandom; oe_p = $urandom;
        v3 = 1'b0; id3 = 2'd0;
        uo_p3 = 24'hA1B2C3; uio_p3 = 24'h445566; oe_p3 = 24'hFFFFFF;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", sel_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ena", ena, 0);
        chk("rst_rst_n", prst, 0);
        chk("rst_pads", {uo, uio, oe}, 0);
        chk("rst_act", act, 0);
        rst_n = 1'b1;
        tick();
        chk("first_ready", sel_ready, 1);

        // Select project 1 from idle: busy for 10 cycles, then active
        uo_p = 32'h44_33_22_11;
        request(2'd1);
        for (int k = 0; k < D + R; k++) begin
            chk("sw1_busy", busy, 1);
            tick();
        end
        chk("sw1_busy_end", busy, 0);
        chk("sw1_uo", uo, 8'h22);
        chk("sw1_rst_n", prst, 4'b0010);

        // Switch 1 -> 2: output enables blanked throughout the switch
        oe_p = 32'h00_5A_FF_00;
        request(2'd2);
        for (int k = 0; k < D + R; k++) begin
            chk("sw2_oe_blank", oe, 0);
            tick();
        end
        chk("sw2_oe", oe, 8'h5A);
        chk("sw2_act", act, 2);

        // Table of successive switches
        for (int i = 0; i < 4; i++) begin
            uo_p = $urandom; uio_p = $urandom; oe_p = $urandom;
            request(tbl[i].id);
            repeat (D + R) tick();
            chk("tbl_act", act, tbl[i].exp_act);
            chk("tbl_rst_n", prst, tbl[i].exp_rst_n);
            chk("tbl_ena", ena, tbl[i].exp_ena);
            chk("tbl_uo", uo, uo_p[8*tbl[i].exp_act +: 8]);
            chk("tbl_uio", uio, uio_p[8*tbl[i].exp_act +: 8]);
        end

        // Re-request active project 0: it is re-reset after the drain
        request(2'd0);
        for (int k = 0; k < D + R; k++) begin
            chk("rereq_rst_low", prst[0], 0);
            chk("rereq_ena", ena[0], (k >= D) ? 1'b1 : 1'b0);
            tick();
        end
        chk("rereq_rst_high", prst[0], 1);

        // Requests during RESET are dropped, not queued
        request(2'd3);
        repeat (D) tick();
        for (int k = 0; k < R; k++) begin
            sel_valid = 1'b1;
            sel_id    = 2'(k % 3);
            chk("ign_ready", sel_ready, 0);
            tick();
        end
        sel_valid = 1'b0;
        chk("ign_act", act, 3);
        chk("ign_rst_n", prst, 4'b1000);
        tick();
        chk("ign_busy_after", busy, 0);

        // NUM_PROJ=3: out-of-range id deselects back to idle
        v3 = 1'b1; id3 = 2'd3;
        tick();
        v3 = 1'b0;
        for (int k = 0; k < D; k++) begin
            chk("d3_drain_busy", busy3, 1);
            chk("d3_drain_ena", ena3, 0);
            tick();
        end
        chk("d3_busy", busy3, 0);
        chk("d3_ena", ena3, 0);
        chk("d3_act", act3, 0);
        chk("d3_ready", r3, 1);
        chk("d3_oe", oe3, 0);

        // Asynchronous reset in the middle of RESET
        request(2'd1);
        repeat (5) tick();
        chk("mid_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_ena", ena, 0);
        chk("mid_rst_n", prst, 0);
        chk("mid_pads", {uo, uio, oe}, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", sel_ready, 0);
        chk("mid_act", act, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_after_ready", sel_ready, 1);
        chk("mid_after_busy", busy, 0);

        // Random requests and pad data against the model
        for (int n = 0; n < 3000; n++) begin
            uo_p      = $urandom;
            uio_p     = $urandom;
            oe_p      = $urandom;
            sel_valid = ($urandom_range(0, 4) == 0);
            sel_id    = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/heichips25_project_mux.md
HEICHIPS25_PROJECT_MUX -- requirements
Module: heichips25_project_mux

Interface
REQ-001 Parameter NUM_PROJ, default 4, number of attached projects (legal 2..4).
REQ-002 Parameter DRAIN_CYCLES, default 2, cycles all project outputs are blanked before a switch (legal 1..15).
REQ-003 Parameter RST_CYCLES, default 8, cycles the newly selected project is held in reset (legal 1..15).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sel_valid  in  1  selection request valid.
- sel_id  in  2  requested project index.
- sel_ready  out  1  request can be accepted.
- uo_out_p  in  8*NUM_PROJ  per-project uo_out; project i at bits [8i+7:8i].
- uio_out_p  in  8*NUM_PROJ  per-project uio_out, same packing.
- uio_oe_p  in  8*NUM_PROJ  per-project uio_oe, same packing.
- proj_ena  out  NUM_PROJ  per-project ena.
- proj_rst_n  out  NUM_PROJ  per-project active-low reset.
- uo_out  out  8  muxed pad output.
- uio_out  out  8  muxed bidir output.
- uio_oe  out  8  muxed bidir output enable.
- active_id  out  2  index of the project currently owning the pads.
- busy  out  1  switch in progress (DRAIN or RESET).

Function
REQ-005 The block SHALL implement a four-state FSM: IDLE, DRAIN, RESET, ACTIVE.
REQ-006 sel_ready SHALL be 1 in IDLE and ACTIVE, and 0 in DRAIN and RESET.
REQ-007 A request is accepted on a rising clk edge where sel_valid=1 and sel_ready=1; sel_id is then captured into a target register.
REQ-008 On acceptance the FSM SHALL enter DRAIN. This applies to any sel_id, including the currently active id, which forces a re-reset of that project.
REQ-009 DRAIN SHALL last exactly DRAIN_CYCLES cycles. Then:
- captured id < NUM_PROJ: go to RESET.
- otherwise: go to IDLE (deselect).
REQ-010 RESET SHALL last exactly RST_CYCLES cycles, then go to ACTIVE. active_id takes the target on entry to RESET.
REQ-011 End-to-end latency: ACTIVE is entered DRAIN_CYCLES+RST_CYCLES edges after the accepting edge.
REQ-012 In IDLE and DRAIN, the block SHALL drive:
- proj_ena=0 and proj_rst_n=0 for all projects.
- uo_out=0, uio_out=0, uio_oe=0.
REQ-013 In RESET, the block SHALL drive:
- proj_ena[active_id]=1, proj_rst_n[active_id]=0.
- All other projects: ena=0, rst_n=0.
- Pad outputs all 0.
REQ-014 In ACTIVE, the block SHALL drive:
- proj_ena[active_id]=1, proj_rst_n[active_id]=1; all others ena=0, rst_n=0.
- uo_out, uio_out and uio_oe combinationally equal to the active project's slices (zero-cycle path).
REQ-015 uio_oe SHALL never be nonzero outside ACTIVE, so the pads never see overlapping drivers during a switch.
REQ-016 sel_valid while sel_ready=0 SHALL be ignored (not queued). The requester must hold the request until it sees sel_ready=1.
REQ-017 busy SHALL be 1 exactly when the state is DRAIN or RESET.
REQ-018 The DRAIN/RESET cycle counter SHALL be 4 bits wide, load on each state entry, count down, and never wrap.

Reset
REQ-019 While rst_n=0, asynchronously:
- state=IDLE, active_id=0, target=0, counter=0.
- All outputs 0, including sel_ready=0.
REQ-020 The first edge after rst_n deassertion SHALL present sel_ready=1. Asserting reset mid-switch or mid-ACTIVE SHALL immediately blank the pads and reset all projects.

Structure
REQ-021 A package heichips25_pmux_pkg SHALL hold:
- the state enum,
- NUM_PROJ_MAX=4,
- the counter width of 4,
- the pad width of 8.
REQ-022 The countdown SHALL live in one sub-module, heichips25_pmux_timer (load, value, done). The FSM and the output mux stay in the top module.

Verification
REQ-023 Reset, then request sel_id=1 at cycle 0 with defaults -> busy=1 for cycles 1-10, ACTIVE at cycle 10, uo_out equals uo_out_p[15:8], proj_rst_n=4'b0010.
REQ-024 With project 1 ACTIVE and uio_oe_p[15:8]=8'hFF, request sel_id=2 -> uio_oe=0 from the next cycle through all of DRAIN/RESET, then uio_oe equals project 2's slice.
REQ-025 With NUM_PROJ=3, request sel_id=3 -> DRAIN for 2 cycles, then IDLE, with all proj_ena=0 and active_id unchanged at 0.
REQ-026 With sel_valid held high and sel_id toggling during RESET -> those requests are ignored, and exactly one switch completes to the originally captured id.
REQ-027 Assert rst_n=0 mid-RESET (cycle 5 of the switch) -> within the same cycle all outputs are 0; after release the block is in IDLE with sel_ready=1.
REQ-028 Re-request the active id 0 while ACTIVE -> proj_rst_n[0] is low for exactly 8 cycles after the 2 drain cycles, then returns high.
